uart_frame_writer: RTL and testbench
====================================

UART_FRAME_WRITER -- requirements
Module: uart_frame_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: memory word-address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 10_000_000: idle-gap limit in clk cycles (100 ms at 100 MHz).
REQ-003 SHALL have port clk  input  1  single system clock (100 MHz domain); all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rxd_data  input  32  received word from the UART receiver.
REQ-006 SHALL have port rxd_valid  input  1  one-cycle strobe qualifying rxd_data.
REQ-007 SHALL have port mem_we  output  1  memory write enable, one cycle per word.
REQ-008 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-009 SHALL have port mem_wdata  output  32  write data.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse on frame completion.
REQ-012 SHALL have port err  output  1  one-cycle pulse on any rejected or aborted word or frame.

Function
REQ-013 SHALL implement the states IDLE, ADDR, DATA, FILLV and FILL; only a qualified word (rxd_valid=1) advances IDLE, ADDR, DATA and FILLV.
REQ-014 SHALL accept a header in IDLE when rxd_data[31:24]=8'hA5, opcode [23:16] is 8'h01 (write) or 8'h02 (fill), and count [15:0] is nonzero; it SHALL latch opcode and count and go to ADDR.
REQ-015 SHALL, for any other word received in IDLE, pulse err one cycle later and remain in IDLE.
REQ-016 SHALL, in ADDR, latch base address = rxd_data[ADDR_W-1:0] and go to DATA for opcode 01, or to FILLV for opcode 02.
REQ-017 SHALL, in DATA, register each word: mem_we=1, mem_addr=current address and mem_wdata=rxd_data, all exactly one cycle after rxd_valid.
REQ-018 SHALL, after each write, increment the address modulo 2^ADDR_W (wrap-around, no error) and decrement the remaining count.
REQ-019 SHALL, in FILLV, latch the fill value and go to FILL.
REQ-020 SHALL, in FILL, issue one write per cycle (mem_wdata = fill value, address increments as in REQ-018) until count reaches zero.
REQ-021 SHALL, when a word arrives during FILL, drop it and pulse err, without disturbing the fill.
REQ-022 SHALL assert done in the same cycle as the last mem_we of a frame, then return to IDLE in the next cycle.
REQ-023 SHALL hold mem_addr and mem_wdata at their last values when mem_we=0.
REQ-024 SHALL keep rxd_valid=1 with a header pattern during DATA as payload (no resync mid-frame).
REQ-025 SHALL have the maximum count 16'hFFFF produce 65535 writes.

Reset
REQ-026 SHALL, on rst=1 at a clk edge, enter IDLE and clear mem_we, mem_addr, mem_wdata, busy, done, err and all internal counters to 0.
REQ-027 SHALL let rst override any simultaneous rxd_valid.
REQ-028 SHALL have a reset during DATA or FILL abandon the frame without issuing further writes or pulsing err or done.
REQ-029 SHALL have the first word accepted after reset release be treated as a header.

Configuration
REQ-030 SHALL, with macro FRAME_TIMEOUT_EN defined, run a gap counter in ADDR, DATA and FILLV that clears on each rxd_valid.
REQ-031 SHALL, with FRAME_TIMEOUT_EN defined and the gap counter reaching TIMEOUT_CYC, pulse err and return to IDLE with no write in that cycle.
REQ-032 SHALL, with FRAME_TIMEOUT_EN not defined, omit the gap counter entirely and wait indefinitely in ADDR, DATA and FILLV.
REQ-033 SHALL NOT apply the timeout in FILL under either setting.

Verification
REQ-034 SHALL cover: words A5010003, 00000010, 11111111, 22222222, 33333333 -> writes at 0x0010/11/12 with the three data words, done with the third write, busy low afterwards.
REQ-035 SHALL cover: words A5020004, 0000FFFE, 0000ABCD -> four consecutive-cycle writes of 0000ABCD at FFFE, FFFF, 0000, 0001; done on the fourth write.
REQ-036 SHALL cover: words 12345678 and then A5030001 in IDLE -> err pulse for each word, no mem_we, state stays IDLE.
REQ-037 SHALL cover: a 1000-word fill with an extra rxd_valid word mid-fill -> single err pulse, exactly 1000 writes, done once.
REQ-038 SHALL cover: rst asserted after the 2nd payload word of a 5-word write -> exactly 2 writes, no done/err, then a fresh header is accepted.
REQ-039 SHALL cover (FRAME_TIMEOUT_EN, TIMEOUT_CYC=100): header plus address, then silence -> err 100 cycles after the address word, back to IDLE; without the macro, busy stays high.

Source files
------------

// File: rtl/uart_frame_writer.sv
// Turns a stream of 32-bit UART words into memory write bursts (write or fill frames).
// Optional idle-gap abort on stalled frames is enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_writer #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       rxd_data,
  input  logic              rxd_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_FILLV,
    S_FILL
  } state_t;

  state_t             r_state, w_state;
  logic               r_is_fill, w_is_fill;
  logic [CNT_W-1:0]   r_count, w_count;
  logic [ADDR_W-1:0]  r_addr, w_addr;
  logic [31:0]        r_fill, w_fill;
  logic               r_mem_we, w_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr, w_mem_addr;
  logic [31:0]        r_mem_wdata, w_mem_wdata;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_err, w_err;
  logic               w_hdr_ok;
  logic               w_last;

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);
  logic [GAP_W-1:0]   r_gap, w_gap;
  logic               w_gap_run;
  logic               w_gap_hit;
`endif

  assign w_hdr_ok = (rxd_data[31:24] == 8'hA5) &&
                    ((rxd_data[23:16] == 8'h01) || (rxd_data[23:16] == 8'h02)) &&
                    (rxd_data[15:0] != 16'h0000);
  assign w_last   = (r_count == CNT_W'(1));

`ifdef FRAME_TIMEOUT_EN
  // Gap counter only runs while waiting on the sender; FILL is self-timed.
  assign w_gap_run = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_FILLV);
  assign w_gap_hit = w_gap_run && !rxd_valid && (r_gap == GAP_W'(TIMEOUT_CYC - 1));
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_is_fill   = r_is_fill;
    w_count     = r_count;
    w_addr      = r_addr;
    w_fill      = r_fill;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_done      = 1'b0;
    w_err       = 1'b0;
`ifdef FRAME_TIMEOUT_EN
    w_gap       = '0;
`endif

    case (r_state)
      S_IDLE: begin
        if (rxd_valid) begin
          if (w_hdr_ok) begin
            w_is_fill = (rxd_data[23:16] == 8'h02);
            w_count   = rxd_data[15:0];
            w_state   = S_ADDR;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (rxd_valid) begin
          w_addr  = rxd_data[ADDR_W-1:0];
          w_state = r_is_fill ? S_FILLV : S_DATA;
        end
      end
      S_DATA: begin
        if (rxd_valid) begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_addr;
          w_mem_wdata = rxd_data;
          w_addr      = r_addr + ADDR_W'(1);
          w_count     = r_count - CNT_W'(1);
          if (w_last) begin
            w_done  = 1'b1;
            w_state = S_IDLE;
          end
        end
      end
      S_FILLV: begin
        if (rxd_valid) begin
          w_fill  = rxd_data;
          w_state = S_FILL;
        end
      end
      S_FILL: begin
        // Incoming words are dropped here but flagged.
        w_err       = rxd_valid;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_fill;
        w_addr      = r_addr + ADDR_W'(1);
        w_count     = r_count - CNT_W'(1);
        if (w_last) begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

`ifdef FRAME_TIMEOUT_EN
    if (w_gap_hit) begin
      w_err   = 1'b1;
      w_state = S_IDLE;
      w_gap   = '0;
    end else if (w_gap_run && !rxd_valid) begin
      w_gap = r_gap + GAP_W'(1);
    end
`endif

    w_busy = (w_state != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_fill   <= 1'b0;
      r_count     <= '0;
      r_addr      <= '0;
      r_fill      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
      r_gap       <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_is_fill   <= w_is_fill;
      r_count     <= w_count;
      r_addr      <= w_addr;
      r_fill      <= w_fill;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
`ifdef FRAME_TIMEOUT_EN
      r_gap       <= w_gap;
`endif
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed bench for uart_frame_writer: write/fill frames, bad headers, reset abort, idle gap.
module tb_uart_frame_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rxd_data;
  logic        rxd_valid;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  uart_frame_writer #(.ADDR_W(16), .TIMEOUT_CYC(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd_data  (rxd_data),
    .rxd_valid (rxd_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Write/event recorder, sampled mid-cycle.
  int          cyc = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  bit          wdn[$];
  int          wc[$];
  int          n_done = 0;
  int          n_err  = 0;
  int          err_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wdn.push_back(done);
      wc.push_back(cyc);
    end
    if (done) n_done <= n_done + 1;
    if (err) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    @(negedge clk);
    wa.delete(); wd.delete(); wdn.delete(); wc.delete();
    n_done = 0;
    n_err  = 0;
  endtask

  task automatic send(input logic [31:0] w);
    rxd_valid = 1'b1;
    rxd_data  = w;
    @(negedge clk);
    rxd_valid = 1'b0;
    rxd_data  = 32'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nbad_fill;
    int addr_cyc;
    rst       = 1'b1;
    rxd_valid = 1'b0;
    rxd_data  = 32'h0;
    idle(3);
    check("rst_we",    64'(mem_we),    64'h0);
    check("rst_addr",  64'(mem_addr),  64'h0);
    check("rst_wdata", 64'(mem_wdata), 64'h0);
    check("rst_busy",  64'(busy),      64'h0);
    check("rst_done",  64'(done),      64'h0);
    check("rst_err",   64'(err),       64'h0);
    rst = 1'b0;
    clear_log();

    // Write frame of three words at 0x0010.
    send(32'hA5010003); send(32'h00000010);
    send(32'h11111111); send(32'h22222222); send(32'h33333333);
    idle(3);
    check("wr_n", 64'(wa.size()), 64'd3);
    if (wa.size() == 3) begin
      check("wr_a0", 64'(wa[0]), 64'h0010); check("wr_d0", 64'(wd[0]), 64'h11111111);
      check("wr_a1", 64'(wa[1]), 64'h0011); check("wr_d1", 64'(wd[1]), 64'h22222222);
      check("wr_a2", 64'(wa[2]), 64'h0012); check("wr_d2", 64'(wd[2]), 64'h33333333);
      check("wr_done_last", 64'(wdn[2]), 64'h1);
      check("wr_done_early", 64'(wdn[0] | wdn[1]), 64'h0);
    end
    check("wr_ndone", 64'(n_done), 64'd1);
    check("wr_nerr",  64'(n_err),  64'd0);
    check("wr_busy",  64'(busy),   64'h0);
    check("wr_hold_addr",  64'(mem_addr),  64'h0012);
    check("wr_hold_wdata", 64'(mem_wdata), 64'h33333333);
    clear_log();

    // Fill of four words wrapping across 0xFFFF.
    send(32'hA5020004); send(32'h0000FFFE); send(32'h0000ABCD);
    idle(8);
    check("fl_n", 64'(wa.size()), 64'd4);
    if (wa.size() == 4) begin
      check("fl_a0", 64'(wa[0]), 64'hFFFE);
      check("fl_a1", 64'(wa[1]), 64'hFFFF);
      check("fl_a2", 64'(wa[2]), 64'h0000);
      check("fl_a3", 64'(wa[3]), 64'h0001);
      check("fl_d3", 64'(wd[3]), 64'h0000ABCD);
      check("fl_consec", 64'(wc[3] - wc[0]), 64'd3);
      check("fl_done_last", 64'(wdn[3]), 64'h1);
    end
    check("fl_ndone", 64'(n_done), 64'd1);
    check("fl_nerr",  64'(n_err),  64'd0);
    check("fl_busy",  64'(busy),   64'h0);
    clear_log();

    // Rejected headers in IDLE.
    send(32'h12345678);
    idle(1);
    send(32'hA5030001);
    idle(3);
    check("bh_nerr", 64'(n_err), 64'd2);
    check("bh_nwr",  64'(wa.size()), 64'd0);
    check("bh_busy", 64'(busy), 64'h0);
    clear_log();

    // 1000-word fill with a stray word mid-fill.
    send(32'hA50203E8); send(32'h00000100); send(32'hDEADBEEF);
    idle(50);
    send(32'h5A5A5A5A);
    for (int i = 0; i < 1200 && n_done == 0; i++) @(negedge clk);
    idle(3);
    check("bf_n",     64'(wa.size()), 64'd1000);
    check("bf_ndone", 64'(n_done), 64'd1);
    check("bf_nerr",  64'(n_err),  64'd1);
    nbad_fill = 0;
    foreach (wd[i]) if (wd[i] !== 32'hDEADBEEF || wa[i] !== 16'(16'h0100 + i)) nbad_fill++;
    check("bf_content", 64'(nbad_fill), 64'd0);
    check("bf_busy", 64'(busy), 64'h0);
    clear_log();

    // Reset after the second payload word of a 5-word write.
    send(32'hA5010005); send(32'h00000200);
    send(32'hAAAA0001); send(32'hAAAA0002);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(5);
    check("ra_n",     64'(wa.size()), 64'd2);
    check("ra_ndone", 64'(n_done), 64'd0);
    check("ra_nerr",  64'(n_err),  64'd0);
    check("ra_busy",  64'(busy),   64'h0);
    clear_log();

    // Fresh frame; a header pattern inside DATA is plain payload.
    send(32'hA5010002); send(32'h00000300);
    send(32'hA5010003); send(32'hCAFEF00D);
    idle(3);
    check("fr_n", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      check("fr_a0", 64'(wa[0]), 64'h0300); check("fr_d0", 64'(wd[0]), 64'hA5010003);
      check("fr_a1", 64'(wa[1]), 64'h0301); check("fr_d1", 64'(wd[1]), 64'hCAFEF00D);
    end
    check("fr_ndone", 64'(n_done), 64'd1);
    check("fr_nerr",  64'(n_err),  64'd0);
    clear_log();

    // Header and address, then silence.
    send(32'hA5010002); send(32'h00000400);
    addr_cyc = cyc;
    idle(150);
`ifdef FRAME_TIMEOUT_EN
    check("to_nerr", 64'(n_err), 64'd1);
    check("to_cyc",  64'(err_cyc - addr_cyc), 64'd100);
    check("to_busy", 64'(busy), 64'h0);
`else
    check("to_busy", 64'(busy), 64'h1);
    check("to_nerr", 64'(n_err), 64'd0);
`endif
    check("to_nwr", 64'(wa.size()), 64'd0);

    // Reset wins over a simultaneous valid header.
    rst       = 1'b1;
    rxd_valid = 1'b1;
    rxd_data  = 32'hA5010001;
    idle(1);
    rst       = 1'b0;
    rxd_valid = 1'b0;
    idle(2);
    check("rv_busy", 64'(busy), 64'h0);
    check("rv_err",  64'(err),  64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
